// File: rtl/entrada_operandos_pkg.sv
// Shared types and widths for the operand-entry controller.
// State codes double as the field indicator shown on the display.
package entrada_operandos_pkg;

  localparam int W_OPERANDO = 4;
  localparam int W_OP       = 3;

  typedef enum logic [2:0] {
    ST_A      = 3'd0,
    ST_B      = 3'd1,
    ST_OP     = 3'd2,
    ST_CIN    = 3'd3,
    ST_PRONTO = 3'd4
  } estado_t;

endpackage

// File: rtl/entrada_operandos_debouncer_botao.sv
// One pushbutton path: 2-FF synchroniser, debounce counter and a one-cycle
// pulse on each accepted press (0->1 of the debounced level).
module debouncer_botao #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      // Any cycle that agrees with the accepted level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/entrada_operandos.sv
// Operand-entry controller: three debounced buttons step through A, B, OP
// and Cin, then hold the completed entry with valid=1 in PRONTO.
module entrada_operandos
  import entrada_operandos_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int OP_MAX          = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_inc,
  input  logic                  btn_next,
  input  logic                  btn_clr,
  output logic [W_OPERANDO-1:0] A_out,
  output logic [W_OPERANDO-1:0] B_out,
  output logic [W_OP-1:0]       OP_out,
  output logic                  Cin_out,
  output logic [2:0]            campo,
  output logic [W_OPERANDO-1:0] valor_edit,
  output logic                  valid
);

  localparam logic [W_OP-1:0] OP_LAST = W_OP'(OP_MAX);

  logic pulse_inc;
  logic pulse_next;
  logic pulse_clr;

  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .btn(btn_inc), .pulse(pulse_inc)
  );
  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .rst_n(rst_n), .btn(btn_next), .pulse(pulse_next)
  );
  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn(btn_clr), .pulse(pulse_clr)
  );

  estado_t               state_q;
  estado_t               state_d;
  logic [W_OPERANDO-1:0] a_d;
  logic [W_OPERANDO-1:0] b_d;
  logic [W_OP-1:0]       op_d;
  logic                  cin_d;
  logic [2:0]            campo_d;
  logic [W_OPERANDO-1:0] valor_d;
  logic                  valid_d;

  // State and every registered output update together, so campo/valor_edit
  // always describe the state currently held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_A;
      A_out      <= '0;
      B_out      <= '0;
      OP_out     <= '0;
      Cin_out    <= 1'b0;
      campo      <= '0;
      valor_edit <= '0;
      valid      <= 1'b0;
    end else begin
      state_q    <= state_d;
      A_out      <= a_d;
      B_out      <= b_d;
      OP_out     <= op_d;
      Cin_out    <= cin_d;
      campo      <= campo_d;
      valor_edit <= valor_d;
      valid      <= valid_d;
    end
  end

  // Pulse priority clr > next > inc; losing pulses are simply dropped.
  always_comb begin
    state_d = state_q;
    a_d     = A_out;
    b_d     = B_out;
    op_d    = OP_out;
    cin_d   = Cin_out;
    if (pulse_clr) begin
      state_d = ST_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      cin_d   = 1'b0;
    end else if (pulse_next) begin
      case (state_q)
        ST_A:      state_d = ST_B;
        ST_B:      state_d = ST_OP;
        ST_OP:     state_d = ST_CIN;
        ST_CIN:    state_d = ST_PRONTO;
        ST_PRONTO: state_d = ST_A;
        default:   state_d = ST_A;
      endcase
    end else if (pulse_inc) begin
      case (state_q)
        ST_A:    a_d   = A_out + 1'b1;
        ST_B:    b_d   = B_out + 1'b1;
        ST_OP:   op_d  = (OP_out >= OP_LAST) ? '0 : OP_out + 1'b1;
        ST_CIN:  cin_d = ~Cin_out;
        default: ;
      endcase
    end
  end

  always_comb begin
    campo_d = state_d;
    valid_d = (state_d == ST_PRONTO);
    valor_d = '0;
    case (state_d)
      ST_A:    valor_d = a_d;
      ST_B:    valor_d = b_d;
      ST_OP:   valor_d = {{(W_OPERANDO-W_OP){1'b0}}, op_d};
      ST_CIN:  valor_d = {{(W_OPERANDO-1){1'b0}}, cin_d};
      default: valor_d = '0;
    endcase
  end

endmodule

// File: tb/tb_entrada_operandos.sv
// Bench for entrada_operandos: directed steps plus a random button walk,
// checked against a field-level model of the entry procedure.
module tb_entrada_operandos;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_clr;
  logic [3:0] A_out;
  logic [3:0] B_out;
  logic [2:0] OP_out;
  logic       Cin_out;
  logic [2:0] campo;
  logic [3:0] valor_edit;
  logic       valid;

  int checks = 0;
  int errors = 0;

  // model: field index 0..4 and the four field values
  int m_campo, m_a, m_b, m_op, m_cin;

  entrada_operandos #(.DEBOUNCE_CYCLES(4), .OP_MAX(6)) dut (
    .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_next(btn_next),
    .btn_clr(btn_clr), .A_out(A_out), .B_out(B_out), .OP_out(OP_out),
    .Cin_out(Cin_out), .campo(campo), .valor_edit(valor_edit), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_campo = 0; m_a = 0; m_b = 0; m_op = 0; m_cin = 0;
  endtask

  // mask bits: 2=clr 1=next 0=inc
  task automatic model_apply(input int mask);
    if (mask & 4) begin
      model_reset();
    end else if (mask & 2) begin
      m_campo = (m_campo + 1) % 5;
    end else if (mask & 1) begin
      case (m_campo)
        0: m_a = (m_a + 1) % 16;
        1: m_b = (m_b + 1) % 16;
        2: m_op = (m_op == 6) ? 0 : m_op + 1;
        3: m_cin = 1 - m_cin;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    int exp_valor;
    case (m_campo)
      0: exp_valor = m_a;
      1: exp_valor = m_b;
      2: exp_valor = m_op;
      3: exp_valor = m_cin;
      default: exp_valor = 0;
    endcase
    chk({tag, ".A"}, int'(A_out), m_a);
    chk({tag, ".B"}, int'(B_out), m_b);
    chk({tag, ".OP"}, int'(OP_out), m_op);
    chk({tag, ".Cin"}, int'(Cin_out), m_cin);
    chk({tag, ".campo"}, int'(campo), m_campo);
    chk({tag, ".valor"}, int'(valor_edit), exp_valor);
    chk({tag, ".valid"}, int'(valid), (m_campo == 4) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic press(input int mask);
    btn_inc  = mask[0];
    btn_next = mask[1];
    btn_clr  = mask[2];
    idle(12);
    btn_inc = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
    idle(12);
    model_apply(mask);
  endtask

  task automatic press_n(input int mask, input int n);
    for (int i = 0; i < n; i++) press(mask);
  endtask

  // OP code 7 must never appear; held operands must not move while valid
  logic       valid_prev = 1'b0;
  logic [11:0] ops_prev = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("op_never_7", int'(OP_out == 3'd7), 0);
      if (valid_prev && valid)
        chk("stable_in_pronto", int'({A_out, B_out, OP_out, Cin_out}), int'(ops_prev));
    end
    valid_prev = valid;
    ops_prev   = {A_out, B_out, OP_out, Cin_out};
  end

  initial begin
    rst_n = 1'b0; btn_inc = 1'b0; btn_next = 1'b0; btn_clr = 1'b0;
    model_reset();
    idle(3);
    check_all("reset");
    rst_n = 1'b1;
    idle(2);

    // reset in the middle of a debounce count: no pulse may follow
    btn_inc = 1'b1;
    idle(4);
    btn_inc = 1'b0;
    rst_n   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(15);
    check_all("reset_mid_count");

    // 3-cycle glitch is rejected
    btn_inc = 1'b1;
    idle(3);
    btn_inc = 1'b0;
    idle(15);
    check_all("glitch");

    // held press: exactly one increment, 7 cycles after the press
    btn_inc = 1'b1;
    idle(6);
    chk("latency_before", int'(A_out), 0);
    idle(1);
    chk("latency_at", int'(A_out), 1);
    idle(13);
    btn_inc = 1'b0;
    idle(12);
    model_apply(1);
    check_all("hold_once");

    // wrap of A and of OP
    press(4);
    press_n(1, 16);
    check_all("a_wrap");
    press_n(2, 2);
    press_n(1, 6);
    check_all("op_at_max");
    press(1);
    check_all("op_wrap");

    // full entry
    press(4);
    press_n(1, 9);  press(2);
    press_n(1, 3);  press(2);
    press_n(1, 5);  press(2);
    press(1);       press(2);
    check_all("pronto");
    chk("pronto.A9", int'(A_out), 9);
    chk("pronto.OP5", int'(OP_out), 5);
    press(1);
    check_all("pronto_inc_ignored");
    press(2);
    check_all("pronto_next");

    // simultaneous buttons
    press(2);
    press(1);
    press(6);
    check_all("clr_next");
    chk("clr_next.campo", int'(campo), 0);
    press_n(1, 2);
    press(3);
    check_all("next_inc");
    chk("next_inc.A", int'(A_out), 2);

    // async reset between clock edges while in ST_OP
    press(2);
    check_all("in_op");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // random walk
    for (int i = 0; i < 70; i++) begin
      int r;
      int mask;
      r = $urandom_range(0, 19);
      if (r == 0)       mask = 4;
      else if (r == 1)  mask = $urandom_range(1, 7);
      else if (r < 8)   mask = 2;
      else              mask = 1;
      press(mask);
      check_all("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
